// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes on the operand and product sides.
// Build option: define EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        count_q, count_d;

  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   acc_done;
  logic                 done_now;

  // One partial product: conditional add into the high half, then shift right with carry into the MSB.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    acc_step = {add_sum, acc_q[WIDTH-1:1]};
  end

`ifdef EARLY_TERM_EN
  logic [CW-1:0] rem;
  logic          rem_zero;

  // rem = multiplier bits still unconsumed after this step; if all zero, finish the shifts at once.
  always_comb begin
    rem      = CW'(WIDTH - 1) - count_q;
    rem_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if ((CW'(i) < rem) && acc_step[i]) begin
        rem_zero = 1'b0;
      end
    end
    done_now = rem_zero;
    acc_done = acc_step >> rem;
  end
`else
  always_comb begin
    done_now = (count_q == CW'(WIDTH - 1));
    acc_done = acc_step;
  end
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = count_q + CW'(1);
        if (done_now) begin
          acc_d     = acc_done;
          product_d = acc_done;
          state_d   = DONE;
        end else begin
          acc_d = acc_step;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Handshake: a transfer happens at a clk edge where valid && ready; in_ready only in IDLE, out_valid only in DONE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier built around the team's 8-bit ripple adder datapath (`eight_bit_adder`: R, C_out).
- Sits downstream of the operand source and upstream of the 8-bit adder.
  - Each RUN cycle it feeds the adder (accumulator high half + multiplicand).
  - It consumes R and C_out on the same cycle.
- Exposes a valid/ready handshake on both the operand side and the product side.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH. Only 8 is verified; other values must still elaborate.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high; clock port is clk, reset port is rst
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid and held
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, unsigned
- busy  output  1  state is RUN

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - product=0, internal acc/mcand/count all 0.
  - Reset overrides every other input, including mid-RUN and mid-DONE; any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
  - busy=1 only in RUN.
- IDLE:
  - On in_valid&&in_ready at an edge: mcand<=a; acc<={WIDTH'b0, b}; count<=0; go to RUN.
  - in_valid=0 keeps IDLE.
- RUN, one partial product per cycle:
  - If acc[0]=1: {c,s} = acc[2W-1:W] + mcand (WIDTH-bit add, c = C_out). Else {c,s} = {0, acc[2W-1:W]}.
  - acc <= {c, s, acc[W-1:1]}, i.e. a right shift with the carry entering the MSB.
  - count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE. Total RUN cycles = WIDTH (8).
- DONE:
  - product <= acc on entry.
  - product is held stable while out_valid=1 && out_ready=0 (backpressure, any duration).
  - out_valid&&out_ready at an edge returns to IDLE. product keeps its last value; out_valid drops.
- Latency: accept at edge N → out_valid high after edge N+WIDTH (8 cycles).
  - Earliest next accept is the edge after the DONE handshake.
  - No overlap between operations.
- Inputs a/b are sampled only at the accept edge; later changes are ignored.
- Width rule: the carry out of the add is never lost, because the product fits exactly in 2*WIDTH bits. Worst case 0xFF*0xFF = 0xFE01.
- The count register is sized ceil(log2(WIDTH))+1 bits and never wraps during RUN.

Optional Feature:
- Macro name: EARLY_TERM_EN.
- Defined:
  - In RUN, if the unconsumed multiplier bits (the remaining low bits of acc not yet shifted out) are all zero, the block jumps to DONE.
  - Before DONE it shifts acc right by (WIDTH-count) in one cycle so the product is correct.
  - Latency is variable, 1..WIDTH cycles.
  - b==0 gives out_valid after 1 RUN cycle.
- Undefined:
  - Fixed WIDTH-cycle RUN.
  - The early-exit logic is absent from the netlist.
- Product values are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 edges, then rst=0 → in_ready=1, out_valid=0, busy=0, product=0x0000.
- Basic: a=0x0D, b=0x0B, in_valid for 1 cycle, out_ready=1 → product=0x008F; out_valid rises exactly 8 cycles after accept (without EARLY_TERM_EN); busy high for 8 cycles.
- Carry extreme: a=0xFF, b=0xFF → product=0xFE01. Also check a=0x00,b=0xA5 → 0x0000 and a=0x80,b=0x02 → 0x0100.
- Backpressure: a=0x12, b=0x34 with out_ready=0 for 5 cycles after out_valid → product stays 0x03A8, in_ready=0; out_ready=1 → IDLE next edge. A new in_valid during DONE is not accepted.
- Reset mid-RUN: accept a=0xFF, b=0xFF, assert rst at the 4th RUN cycle → next edge IDLE, out_valid never pulses; then a=0x03, b=0x05 → 0x000F.
- EARLY_TERM_EN build: a=0x12, b=0x01 → product=0x0012 with out_valid 1 cycle after accept; a=0x12, b=0x80 → 0x0900 after 8 cycles. Random 10-pair sweep ($random) matches a*b in both builds.
